rv32i_regfile: RTL and testbench
================================

// Module: rv32i_regfile
// PURPOSE
//  RV32I integer register file: 32 x 32-bit general-purpose registers x0..x31, single shared address port.
//  A mode input selects read (combinational) or write (clocked) each cycle.
//  x0 is hardwired to zero.
//  Sits in the decode/writeback path of the DaVinci RV32I core.
// PARAMETERS
//  XLEN        32  register data width (bits)
//  ADDR_W      5   register index width
//  NUM_REGS    32  architectural register count (16 when RV32E_MODE_EN defined)
// PORTS
//  clk      in   1       single clock; all state updates on rising edge
//  rst      in   1       synchronous, active-high reset
//  state    in   1       1 = read, 0 = write
//  address  in   ADDR_W  register index for read or write
//  data_w   in   XLEN    write data
//  data     out  XLEN    read data
// BEHAVIOUR
//  - Reset: on rising clk with rst=1, all registers x1..x31 clear to 32'h0; rst has priority over write.
//  - Write: on rising clk with rst=0 and state=0, reg[address] <= data_w.
//    Exception: address=0 is ignored, so x0 stays 0.
//  - Read: purely combinational, zero latency.
//    - state=1: data = reg[address], or 32'h0 if address=0.
//    - state=0: data = 32'h0 (output quiet during write cycles).
//  - No write-to-read bypass: a value written at edge N is visible on data from edge N onward once state=1.
//  - data is 32'h0 during and immediately after reset, for any address.
//  - No handshake, no stall. One operation per cycle.
//  - Address always in range for 32 regs; no wrap logic needed.
//  - x0 is implemented as a constant, not a storage flop.
// CONFIGURATION
//  Macro RV32E_MODE_EN:
//  - Defined: 16 registers (x0..x15).
//    - Writes with address[4]=1 are dropped.
//    - Reads with address[4]=1 return 32'h0.
//  - Undefined (default): full 32-register RV32I file; address[4] decoded normally.
// STRUCTURE
//  - Shared package rv32i_pkg: XLEN, REG_ADDR_W, NUM_REGS constants; reg_idx_t (5-bit) and word_t (32-bit) typedefs.
//  - Single flat module; storage array plus write-enable decode and read mux.
//  - No sub-module required.
// TESTING
//  1. Reset, then state=1, address=0 -> data=32'h00000000.
//  2. state=0, address=1, data_w=32'hF000000F, one clk edge;
//     then state=1, address=1 -> data=32'hF000000F.
//  3. state=0, address=0, data_w=32'hFFFFFFFF, clk edge;
//     then state=1, address=0 -> data=32'h00000000.
//  4. Write 32'hA5A5A5A5 to x31, assert rst one cycle,
//     then read x31 -> 32'h00000000.
//  5. Write i*32'h01010101 to each x1..x31, read back all;
//     each matches, no aliasing, x0=0.
//  6. With RV32E_MODE_EN: write 32'h12345678 to x17, read x17 -> 32'h0;
//     write/read x15 -> 32'h12345678.

Source files
------------

// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg : shared RV32I register-file constants and types (RV32E_MODE_EN)
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
`ifdef RV32E_MODE_EN
   localparam int NUM_REGS   = 16;
`else
   localparam int NUM_REGS   = 32;
`endif

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]       word_t;

endpackage

`default_nettype wire

// File: rtl/rv32i_regfile.sv
// ---------------------------------------------------------------------------
// rv32i_regfile : RV32I register file, shared address, x0 constant zero.
// Config macro  : RV32E_MODE_EN (16 registers).
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv32i_regfile
   import rv32i_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  state,
   input  logic [REG_ADDR_W-1:0] address,
   input  logic [XLEN-1:0]       data_w,
   output logic [XLEN-1:0]       data
);

   word_t r_regs [1:NUM_REGS-1];
   logic  w_in_range;
   logic  w_we;

`ifdef RV32E_MODE_EN
   assign w_in_range = ~address[REG_ADDR_W-1];
`else
   assign w_in_range = 1'b1;
`endif

   assign w_we = ~state & w_in_range;

   // x0 has no storage; only x1..x(NUM_REGS-1) get flops.
   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk) begin
         if (rst) begin
            r_regs[gi] <= '0;
         end else if (w_we && (address == REG_ADDR_W'(gi))) begin
            r_regs[gi] <= data_w;
         end
      end
   end

   always_comb begin
      data = '0;
      if (!rst && state && w_in_range) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (address == REG_ADDR_W'(i)) begin
               data = r_regs[i];
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_regfile.sv
// ---------------------------------------------------------------------------
// tb_rv32i_regfile : randomized self-checking bench for rv32i_regfile.
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rv32i_regfile;
   import rv32i_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              state = 1'b1;
   logic [4:0]        address = '0;
   logic [31:0]       data_w = '0;
   logic [31:0]       data;

   int errs   = 0;
   int checks = 0;
   logic [31:0] mem [32];

   rv32i_regfile dut (
      .clk     (clk),
      .rst     (rst),
      .state   (state),
      .address (address),
      .data_w  (data_w),
      .data    (data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] expect_read(input logic r, input logic st, input logic [4:0] a);
      if (r || !st || a == 0 || int'(a) >= NUM_REGS) return 32'h0;
      return mem[a];
   endfunction

   // Apply one cycle of inputs, check the combinational output, then clock it.
   task automatic step(input string tag, input logic r, input logic st,
                       input logic [4:0] a, input logic [31:0] d);
      rst = r; state = st; address = a; data_w = d;
      #1;
      check(tag, data, expect_read(r, st, a));
      @(posedge clk);
      if (r) begin
         for (int k = 0; k < 32; k++) mem[k] = 32'h0;
      end else if (!st && a != 0 && int'(a) < NUM_REGS) begin
         mem[a] = d;
      end
      #1;
   endtask

   initial begin
      for (int k = 0; k < 32; k++) mem[k] = 32'h0;
      @(posedge clk); #1;

      // 1: reset then read x0
      step("rst_hold", 1'b1, 1'b1, 5'd7, 32'h0);
      step("t1_x0", 1'b0, 1'b1, 5'd0, 32'h0);
      step("t1_x9_after_rst", 1'b0, 1'b1, 5'd9, 32'h0);

      // 2: write/read x1
      step("t2_wr_quiet", 1'b0, 1'b0, 5'd1, 32'hF000000F);
      step("t2_rd_x1", 1'b0, 1'b1, 5'd1, 32'h0);
      check("t2_literal", data, 32'hF000000F);

      // 3: write to x0 ignored
      step("t3_wr_x0", 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF);
      step("t3_rd_x0", 1'b0, 1'b1, 5'd0, 32'h0);

      // 4: reset clears x31
      step("t4_wr_x31", 1'b0, 1'b0, 5'd31, 32'hA5A5A5A5);
      step("t4_rd_x31_pre", 1'b0, 1'b1, 5'd31, 32'h0);
      step("t4_rst_wr", 1'b1, 1'b0, 5'd31, 32'h5A5A5A5A);
      step("t4_rd_x31", 1'b0, 1'b1, 5'd31, 32'h0);
      check("t4_literal", data, 32'h0);

      // 5: fill all registers, read back
      for (int i = 1; i < 32; i++)
         step("t5_wr", 1'b0, 1'b0, 5'(i), 32'(i) * 32'h01010101);
      for (int i = 0; i < 32; i++)
         step("t5_rd", 1'b0, 1'b1, 5'(i), 32'h0);

      // 6: upper half behaviour (dropped in RV32E, normal otherwise)
      step("t6_wr_x17", 1'b0, 1'b0, 5'd17, 32'h12345678);
      step("t6_rd_x17", 1'b0, 1'b1, 5'd17, 32'h0);
      step("t6_wr_x15", 1'b0, 1'b0, 5'd15, 32'h12345678);
      step("t6_rd_x15", 1'b0, 1'b1, 5'd15, 32'h0);
      check("t6_literal_x15", data, 32'h12345678);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         step("rand",
              ($urandom_range(0, 60) == 0),
              1'($urandom),
              5'($urandom),
              ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : 32'($urandom));
      end

      // final sweep
      for (int i = 0; i < 32; i++)
         step("final_rd", 1'b0, 1'b1, 5'(i), 32'h0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

`default_nettype wire
